ppmi: RTL and testbench
=======================

# ppmi

Pulse-position input decoder for the robot SoC. It sits upstream of the servo PPM generator. It decodes the composite PPM stream from an RC receiver or from a looped-back PPM output into eight 8-bit channel values, using the same 0..255 scale the generator consumes. The values are exposed as two read-only 32-bit bus words plus a status word, so firmware can read them and forward them to the servo holding registers. The block also supplies a frame strobe and a link-lost flag for the emergency-brake logic.

## Interface
Parameters:
- DIV, 195: prescaler terminal count; tick = DIV+1 = 196 clk = 3.92 µs at 50 MHz.
- OFS, 257: tick offset subtracted from a channel interval; interval of 257+v ticks decodes to v.
- MIN_TICKS, 240: shortest legal channel interval, in ticks.
- MAX_TICKS, 540: longest legal channel interval, in ticks.
- SYNC_TICKS, 768: an interval ≥ this is a frame sync gap (~3.0 ms).
- WDT_BITS, 24: link watchdog width; timeout = 2^(WDT_BITS-1) clk (~168 ms).

Ports:
- clk, in, 1: 50 MHz system clock; single clock domain.
- rst, in, 1: synchronous, active-high reset.
- ppm_in, in, 1: asynchronous PPM stream; rising edge marks a channel boundary.
- we_sts, in, 1: bus write strobe to the status word; clears the frame and error counters.
- rdt_03, out, 32: {val[3], val[2], val[1], val[0]}.
- rdt_47, out, 32: {val[7], val[6], val[5], val[4]}.
- rdt_sts, out, 32: {frm_cnt[15:0], err_cnt[7:0], 7'b0, lost}.
- frm, out, 1: one-clk pulse when a complete frame is committed.
- lost, out, 1: no valid frame committed within the watchdog timeout.

## Operation
- **Input conditioning:**
  - 2-FF synchronizer on ppm_in, then a registered rising-edge detector, giving `edge`.
  - No falling-edge use; pulse width is ignored.
- **Prescaler:**
  - div counts 0..DIV and asserts tick at DIV.
  - div is cleared on `edge`, so intervals align to edges.
- **Interval counter:**
  - cnt, 12 bits, increments on tick and saturates at 4095.
  - On `edge` the current cnt is evaluated, then cnt is cleared.
  - An interval of N·196 clk between edges yields cnt = N exactly.
- **Decode:**
  - v = sat(cnt − OFS).
  - cnt < OFS → 0; cnt − OFS > 255 → 255.
- **FSM, two states:**
  - **HUNT**
    - `edge` with cnt ≥ SYNC_TICKS → RUN, idx = 0.
    - Any other `edge` is ignored.
  - **RUN**
    - `edge` with MIN_TICKS ≤ cnt ≤ MAX_TICKS: shadow[idx] ← v, idx++.
    - If idx was 7: commit all 8 shadow values to val[] in one cycle, pulse frm, frm_cnt++, clear wdt, lost ← 0, → HUNT.
    - `edge` with cnt outside [MIN_TICKS, MAX_TICKS]: err_cnt++, discard shadow, → HUNT. A sync-length interval here is still an error, and is not also taken as a sync.
    - No `edge` and cnt reaches SYNC_TICKS (short frame): err_cnt++, → HUNT. The next edge then qualifies as sync.
- **Frame and error counters:**
  - frm_cnt (16-bit) and err_cnt (8-bit) wrap.
  - we_sts clears both. A simultaneous increment is lost, because the clear wins.
- **Watchdog:**
  - wdt counts clk and holds once its MSB is set.
  - MSB set → lost = 1 and all val[] = 8'h80.
  - val[] stays at 8'h80 until the next commit.
- **Partial updates:** val[] never shows a mix of two frames; only a full 8-channel commit writes it.

## Timing
- **Reset values:**
  - val[0..7] = 8'h80, so rdt_03 = rdt_47 = 32'h80808080.
  - lost = 1.
  - frm = 0.
  - frm_cnt = err_cnt = 0, so rdt_sts = 32'h00000001.
  - FSM = HUNT; cnt = 4095 (saturated), so the first edge after reset qualifies as sync.
  - div = 0, idx = 0, wdt = 0.
- **Latency:**
  - ppm_in rising → `edge` high 3 clk later.
  - Commit (val[], frm, lost) is visible 1 clk after the `edge` cycle.
  - The bus read outputs are combinational from val[] and the status registers.
- **Priority when events coincide:**
  - rst over everything.
  - Watchdog expiry in the same cycle as a commit: the commit wins, lost = 0, and the new values are kept.
  - `edge` and tick in the same cycle: the edge wins (cnt is compared before the increment, then cleared).
- **Reset mid-frame:** discards the shadow and returns all state to reset values on the next clk.

## Structure
- Shared package ppm_pkg:
  - Tick constants (DIV, OFS; also used by the PPM generator).
  - Neutral value 8'h80.
  - FSM state enum {HUNT, RUN}.
- One natural sub-module, ppm_edge: synchronizer plus rising-edge detector, reusable for other receiver inputs.
- All other logic lives in the top module.

## Test plan
- Post-reset, no input → rdt_03 = rdt_47 = 32'h80808080, rdt_sts = 32'h00000001, frm never pulses.
- Loopback from the PPM generator with values 00,40,80,C0,FF,01,7F,FE → after the first full frame, rdt_03 = 32'hC0804000, rdt_47 = 32'hFE7F01FF, frm one pulse per frame, lost = 0.
- Inject one channel interval of 200 ticks mid-frame → err_cnt = 1, no frm for that frame, val[] unchanged, recovery on the next frame.
- Frame of only 5 pulses, then a 2056-tick gap → err_cnt++, next complete frame commits correctly.
- Stop the input after a valid frame → lost = 1 and val[] = 8'h80 exactly 2^23 clk after the last frm. Resume → lost = 0 on the first committed frame.
- we_sts pulse after 3 frames → rdt_sts[31:8] = 0. Separately, assert rst between channel 3 and channel 4 → all values at reset, no partial commit.

Source files
------------

// File: rtl/ppm_pkg.sv
// rtl/ppm_pkg.sv - shared PPM tick constants, neutral value, FSM states and decode helper
package ppm_pkg;

    // Tick timing shared with the PPM generator
    localparam int PPM_DIV        = 195;
    localparam int PPM_OFS        = 257;
    localparam int PPM_MIN_TICKS  = 240;
    localparam int PPM_MAX_TICKS  = 540;
    localparam int PPM_SYNC_TICKS = 768;
    localparam int PPM_WDT_BITS   = 24;

    // Interval counter geometry
    localparam int          PPM_CNT_W   = 12;
    localparam logic [11:0] PPM_CNT_MAX = 12'hFFF;

    // Servo centre position, used at reset and on link loss
    localparam logic [7:0] PPM_NEUTRAL = 8'h80;

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } ppm_state_e;

    // Saturating conversion of a channel interval (ticks) to the 0..255 scale
    function automatic logic [7:0] ppm_decode(input logic [11:0] cnt, input logic [11:0] ofs);
        logic [11:0] diff;
        diff = cnt - ofs;
        if (cnt < ofs) begin
            return 8'h00;
        end else if (diff > 12'd255) begin
            return 8'hFF;
        end else begin
            return diff[7:0];
        end
    endfunction

endpackage

// File: rtl/ppm_edge.sv
// rtl/ppm_edge.sv - two-flop synchronizer with registered rising-edge detector
module ppm_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_rise
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic r_rise;

    // Synchronize the async input, then flag a 0->1 transition one cycle wide
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_rise  <= 1'b0;
        end else begin
            r_sync1 <= i_async;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_rise  <= r_sync2 & ~r_prev;
        end
    end

    assign o_rise = r_rise;

endmodule

// File: rtl/ppmi.sv
// rtl/ppmi.sv - PPM input decoder: eight channel values, frame strobe and link-lost flag
module ppmi
    import ppm_pkg::*;
#(
    parameter int DIV        = PPM_DIV,
    parameter int OFS        = PPM_OFS,
    parameter int MIN_TICKS  = PPM_MIN_TICKS,
    parameter int MAX_TICKS  = PPM_MAX_TICKS,
    parameter int SYNC_TICKS = PPM_SYNC_TICKS,
    parameter int WDT_BITS   = PPM_WDT_BITS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ppm_in,
    input  logic        we_sts,
    output logic [31:0] rdt_03,
    output logic [31:0] rdt_47,
    output logic [31:0] rdt_sts,
    output logic        frm,
    output logic        lost
);

    localparam int DIV_W = $clog2(DIV + 2);

    localparam logic [DIV_W-1:0]     L_DIV  = DIV_W'(DIV);
    localparam logic [PPM_CNT_W-1:0] L_OFS  = PPM_CNT_W'(OFS);
    localparam logic [PPM_CNT_W-1:0] L_MIN  = PPM_CNT_W'(MIN_TICKS);
    localparam logic [PPM_CNT_W-1:0] L_MAX  = PPM_CNT_W'(MAX_TICKS);
    localparam logic [PPM_CNT_W-1:0] L_SYNC = PPM_CNT_W'(SYNC_TICKS);
    localparam logic [WDT_BITS-1:0]  L_WDT_LAST = {1'b0, {(WDT_BITS-1){1'b1}}};

    logic                  w_edge;
    logic                  w_tick;
    logic [7:0]            w_val;
    logic                  w_in_range;
    logic                  w_wdt_expire;
    logic [7:0][7:0]       w_next_shadow;

    logic [DIV_W-1:0]      r_div;
    logic [PPM_CNT_W-1:0]  r_cnt;
    ppm_state_e            r_state;
    logic [2:0]            r_idx;
    logic [7:0][7:0]       r_shadow;
    logic [7:0][7:0]       r_val;
    logic [15:0]           r_frm_cnt;
    logic [7:0]            r_err_cnt;
    logic [WDT_BITS-1:0]   r_wdt;
    logic                  r_lost;
    logic                  r_frm;

    ppm_edge u_edge (
        .clk     (clk),
        .rst     (rst),
        .i_async (ppm_in),
        .o_rise  (w_edge)
    );

    assign w_tick       = (r_div == L_DIV);
    assign w_val        = ppm_decode(r_cnt, L_OFS);
    assign w_in_range   = (r_cnt >= L_MIN) && (r_cnt <= L_MAX);
    assign w_wdt_expire = (r_wdt == L_WDT_LAST);

    // Shadow image including the channel being captured this cycle
    always_comb begin
        w_next_shadow        = r_shadow;
        w_next_shadow[r_idx] = w_val;
    end

    // Prescaler; the edge cycle itself is tick phase 0, so cnt = floor(interval / (DIV+1))
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div <= '0;
        end else if (w_edge) begin
            r_div <= DIV_W'(1);
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    // Interval counter in ticks, saturating so a long idle line always reads as sync
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= PPM_CNT_MAX;
        end else if (w_edge) begin
            r_cnt <= '0;
        end else if (w_tick && (r_cnt != PPM_CNT_MAX)) begin
            r_cnt <= r_cnt + PPM_CNT_W'(1);
        end
    end

    // Frame FSM with channel capture, commit, counters and link watchdog
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= HUNT;
            r_idx     <= '0;
            r_shadow  <= '0;
            r_val     <= {8{PPM_NEUTRAL}};
            r_frm_cnt <= '0;
            r_err_cnt <= '0;
            r_wdt     <= '0;
            r_lost    <= 1'b1;
            r_frm     <= 1'b0;
        end else begin
            r_frm <= 1'b0;

            if (!r_wdt[WDT_BITS-1]) begin
                r_wdt <= r_wdt + WDT_BITS'(1);
            end
            if (w_wdt_expire) begin
                r_lost <= 1'b1;
                r_val  <= {8{PPM_NEUTRAL}};
            end

            case (r_state)
                HUNT: begin
                    if (w_edge && (r_cnt >= L_SYNC)) begin
                        r_state <= RUN;
                        r_idx   <= '0;
                    end
                end
                RUN: begin
                    if (w_edge) begin
                        if (w_in_range) begin
                            r_shadow <= w_next_shadow;
                            r_idx    <= r_idx + 3'd1;
                            if (r_idx == 3'd7) begin
                                // Commit overrides a coincident watchdog expiry
                                r_val     <= w_next_shadow;
                                r_frm     <= 1'b1;
                                r_frm_cnt <= r_frm_cnt + 16'd1;
                                r_wdt     <= '0;
                                r_lost    <= 1'b0;
                                r_state   <= HUNT;
                            end
                        end else begin
                            r_err_cnt <= r_err_cnt + 8'd1;
                            r_state   <= HUNT;
                        end
                    end else if (r_cnt >= L_SYNC) begin
                        // Sync gap arrived before eight channels: short frame
                        r_err_cnt <= r_err_cnt + 8'd1;
                        r_state   <= HUNT;
                    end
                end
                default: r_state <= HUNT;
            endcase

            // Bus clear takes precedence over any increment in the same cycle
            if (we_sts) begin
                r_frm_cnt <= '0;
                r_err_cnt <= '0;
            end
        end
    end

    assign rdt_03  = r_val[3:0];
    assign rdt_47  = r_val[7:4];
    assign rdt_sts = {r_frm_cnt, r_err_cnt, 7'b0, r_lost};
    assign frm     = r_frm;
    assign lost    = r_lost;

endmodule

// File: tb/tb_ppmi.sv
// tb/tb_ppmi.sv - directed self-checking bench for ppmi
module tb_ppmi;

    localparam int DIV      = 1;
    localparam int TICK_CLK = DIV + 1;
    localparam int WDT_BITS = 15;
    localparam int WDT_TO   = 1 << (WDT_BITS - 1);
    localparam int SYNC_GAP = 800;
    localparam int HI_CLK   = 40;

    typedef int ticks_t [8];

    logic        clk = 1'b0;
    logic        rst;
    logic        ppm_in;
    logic        we_sts;
    logic [31:0] rdt_03;
    logic [31:0] rdt_47;
    logic [31:0] rdt_sts;
    logic        frm;
    logic        lost;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_rise_cyc = 0;
    int last_frm_cyc = 0;
    int frm_seen = 0;
    logic frm_q = 1'b0;

    ticks_t frame_a = '{257, 321, 385, 449, 512, 258, 384, 511};
    ticks_t frame_b = '{273, 289, 305, 321, 337, 353, 369, 385};
    ticks_t frame_c = '{250, 257, 512, 513, 530, 540, 240, 300};

    ppmi #(
        .DIV      (DIV),
        .WDT_BITS (WDT_BITS)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ppm_in  (ppm_in),
        .we_sts  (we_sts),
        .rdt_03  (rdt_03),
        .rdt_47  (rdt_47),
        .rdt_sts (rdt_sts),
        .frm     (frm),
        .lost    (lost)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (frm) begin
            check("frm_width", {31'd0, frm_q}, 32'd0);
            check("frm_latency", cyc - last_rise_cyc, 32'd4);
            frm_seen     <= frm_seen + 1;
            last_frm_cyc <= cyc;
        end
        frm_q <= frm;
    end

    // Rising edge now; the next emit's edge follows after the given number of ticks
    task automatic emit(input int ticks);
        ppm_in = 1'b1;
        last_rise_cyc = cyc;
        repeat (HI_CLK) @(negedge clk);
        ppm_in = 1'b0;
        repeat (ticks * TICK_CLK - HI_CLK) @(negedge clk);
    endtask

    task automatic send_frame(input ticks_t t);
        for (int i = 0; i < 8; i++) emit(t[i]);
        emit(SYNC_GAP);
    endtask

    initial begin
        int w;
        rst    = 1'b1;
        ppm_in = 1'b0;
        we_sts = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rdt03", rdt_03, 32'h80808080);
        check("rst_rdt47", rdt_47, 32'h80808080);
        check("rst_sts", rdt_sts, 32'h00000001);
        check("rst_lost", {31'd0, lost}, 32'd1);
        check("rst_frm", {31'd0, frm}, 32'd0);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        check("idle_no_frm", frm_seen, 32'd0);

        send_frame(frame_a);
        check("a1_rdt03", rdt_03, 32'hC0804000);
        check("a1_rdt47", rdt_47, 32'hFE7F01FF);
        check("a1_lost", {31'd0, lost}, 32'd0);
        check("a1_frm", frm_seen, 32'd1);
        send_frame(frame_a);
        check("a2_frm", frm_seen, 32'd2);
        check("a2_sts", rdt_sts, 32'h00020000);

        emit(257); emit(321); emit(385); emit(200); emit(SYNC_GAP);
        check("err_sts", rdt_sts, 32'h00020100);
        check("err_rdt03", rdt_03, 32'hC0804000);
        check("err_rdt47", rdt_47, 32'hFE7F01FF);
        check("err_frm", frm_seen, 32'd2);

        send_frame(frame_b);
        check("b_rdt03", rdt_03, 32'h40302010);
        check("b_rdt47", rdt_47, 32'h80706050);
        check("b_sts", rdt_sts, 32'h00030100);

        emit(300); emit(300); emit(300); emit(300); emit(2056);
        check("short_sts", rdt_sts, 32'h00030200);
        check("short_rdt03", rdt_03, 32'h40302010);

        send_frame(frame_c);
        check("c_rdt03", rdt_03, 32'hFFFF0000);
        check("c_rdt47", rdt_47, 32'h2B00FFFF);
        check("c_sts", rdt_sts, 32'h00040200);

        w = 0;
        while (!lost && w < WDT_TO + 100) begin
            @(negedge clk);
            w++;
        end
        check("wdt_delay", cyc - last_frm_cyc, WDT_TO);
        check("wdt_rdt03", rdt_03, 32'h80808080);
        check("wdt_rdt47", rdt_47, 32'h80808080);
        check("wdt_sts", rdt_sts, 32'h00040201);

        send_frame(frame_a);
        check("resume_lost", {31'd0, lost}, 32'd0);
        check("resume_rdt03", rdt_03, 32'hC0804000);
        check("resume_rdt47", rdt_47, 32'hFE7F01FF);
        check("resume_sts", rdt_sts, 32'h00050200);

        we_sts = 1'b1;
        @(negedge clk);
        we_sts = 1'b0;
        @(negedge clk);
        check("clr_sts", rdt_sts, 32'h00000000);
        check("clr_rdt03", rdt_03, 32'hC0804000);

        emit(257); emit(321); emit(385); emit(449);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_rdt03", rdt_03, 32'h80808080);
        check("midrst_rdt47", rdt_47, 32'h80808080);
        check("midrst_sts", rdt_sts, 32'h00000001);
        check("midrst_lost", {31'd0, lost}, 32'd1);
        rst = 1'b0;
        emit(512); emit(258); emit(384); emit(511); emit(SYNC_GAP);
        check("post_frm", frm_seen, 32'd5);
        check("post_rdt03", rdt_03, 32'h80808080);
        check("post_sts", rdt_sts, 32'h00000101);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
